// File: rtl/div256by128_seq_if.sv
// Request/response bundle for the 2*DW / DW sequential divider.
// Both directions are valid/ready: a word moves on a rising edge with valid && ready; valid holds its payload until then.
interface div256by128_seq_if #(
  parameter int DW = 128
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend_hi;
  logic [DW-1:0] dividend_lo;
  logic [DW-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [DW-1:0] remainder;
  logic          div_by_zero;
  logic          overflow;

  modport master (
    output in_valid, dividend_hi, dividend_lo, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  in_valid, dividend_hi, dividend_lo, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/div256by128_seq.sv
// Radix-2 restoring divider: {dividend_hi, dividend_lo} / divisor, one quotient bit per cycle.
// Divide-by-zero and quotient-overflow cases skip iteration and complete in one cycle.
module div256by128_seq #(
  parameter int DW    = 128,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  div256by128_seq_if.slave       bus,
  output logic [1:0]             state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [DW-1:0]  r_q;
  logic [DW-1:0]  q_q;
  logic [DW-1:0]  dvsr_q;
  logic [CNT_W-1:0] cnt;

  logic [DW:0]    trial;
  logic [DW:0]    diff;
  logic           ge;
  logic [DW-1:0]  r_nxt;
  logic [DW-1:0]  q_nxt;

  // R < divisor keeps trial < 2*divisor, so the borrow bit alone decides trial >= divisor.
  always_comb begin
    trial = {r_q, q_q[DW-1]};
    diff  = trial - {1'b0, dvsr_q};
    ge    = ~diff[DW];
    r_nxt = ge ? diff[DW-1:0] : trial[DW-1:0];
    q_nxt = {q_q[DW-2:0], ge};
  end

  assign bus.in_ready = (state == IDLE);
  assign state_dbg    = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      r_q             <= '0;
      q_q             <= '0;
      dvsr_q          <= '0;
      cnt             <= '0;
      bus.out_valid   <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
      bus.overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            if (bus.divisor == '0) begin
              bus.quotient    <= '1;
              bus.remainder   <= bus.dividend_lo;
              bus.div_by_zero <= 1'b1;
              bus.overflow    <= 1'b0;
              bus.out_valid   <= 1'b1;
              state           <= DONE;
            end else if (bus.dividend_hi >= bus.divisor) begin
              bus.quotient    <= '1;
              bus.remainder   <= '0;
              bus.div_by_zero <= 1'b0;
              bus.overflow    <= 1'b1;
              bus.out_valid   <= 1'b1;
              state           <= DONE;
            end else begin
              dvsr_q <= bus.divisor;
              r_q    <= bus.dividend_hi;
              q_q    <= bus.dividend_lo;
              cnt    <= '0;
              state  <= CALC;
            end
          end
        end
        CALC: begin
          r_q <= r_nxt;
          q_q <= q_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(DW - 1)) begin
            bus.quotient    <= q_nxt;
            bus.remainder   <= r_nxt;
            bus.div_by_zero <= 1'b0;
            bus.overflow    <= 1'b0;
            bus.out_valid   <= 1'b1;
            state           <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div256by128_seq.sv
// Randomised and directed bench for div256by128_seq against a 256-bit arithmetic reference.
module tb_div256by128_seq;
  localparam int DW = 128;

  typedef struct packed {
    logic [DW-1:0] q;
    logic [DW-1:0] r;
    logic          dbz;
    logic          ovf;
    logic [31:0]   acc;
    logic [31:0]   lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  state_dbg;
  logic [31:0] cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          ready_mode = 1;   // 0 hold low, 1 hold high, 2 random
  logic [31:0] last_acc = 0;
  exp_t        exp_q[$];

  div256by128_seq_if #(.DW(DW)) bus ();

  div256by128_seq #(.DW(DW), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Reference: plain 256-bit division plus the two exception rules.
  function automatic exp_t model(input logic [DW-1:0] hi, input logic [DW-1:0] lo,
                                 input logic [DW-1:0] dv);
    exp_t e;
    logic [2*DW-1:0] n;
    logic [2*DW-1:0] d;
    e = '0;
    n = {hi, lo};
    d = {{DW{1'b0}}, dv};
    if (dv == 0) begin
      e.q = '1; e.r = lo; e.dbz = 1'b1; e.lat = 1;
    end else if (hi >= dv) begin
      e.q = '1; e.r = '0; e.ovf = 1'b1; e.lat = 1;
    end else begin
      e.q = DW'(n / d); e.r = DW'(n % d); e.lat = DW + 1;
    end
    return e;
  endfunction

  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic issue(input logic [DW-1:0] hi, input logic [DW-1:0] lo, input logic [DW-1:0] dv);
    exp_t e;
    int   n;
    @(negedge clk);
    bus.dividend_hi = hi;
    bus.dividend_lo = lo;
    bus.divisor     = dv;
    bus.in_valid    = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!bus.in_ready) begin
      failures++;
      $display("FAIL accept_timeout: in_ready 0 expected 1");
    end else begin
      e = model(hi, lo, dv);
      e.acc = cyc;
      last_acc = cyc;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", DW'(exp_q.size()), '0);
  endtask

  always @(negedge clk) begin
    #1;
    case (ready_mode)
      0:       bus.out_ready = 1'b0;
      1:       bus.out_ready = 1'b1;
      default: bus.out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor: latency on first sight of out_valid, payload on handshake.
  initial begin : monitor
    bit   seen;
    exp_t e;
    seen = 0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        seen = 0;
      end else if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_result: out_valid 1 with empty queue");
          seen = 1;
        end else begin
          e = exp_q[0];
          if (!seen) begin
            seen = 1;
            chk("latency", DW'(cyc - e.acc), DW'(e.lat));
          end
          chk("in_ready_busy", DW'(bus.in_ready), '0);
          if (bus.out_ready) begin
            chk("quotient", bus.quotient, e.q);
            chk("remainder", bus.remainder, e.r);
            chk("div_by_zero", DW'(bus.div_by_zero), DW'(e.dbz));
            chk("overflow", DW'(bus.overflow), DW'(e.ovf));
            void'(exp_q.pop_front());
            seen = 0;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks + 1, failures);
    $finish;
  end

  initial begin : main
    logic [DW-1:0] hi, lo, dv;
    logic [DW-1:0] hold_q, hold_r;
    logic [31:0]   hs_cyc;
    int            n;
    exp_t          e;

    bus.in_valid = 1'b0;
    bus.dividend_hi = '0;
    bus.dividend_lo = '0;
    bus.divisor = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", DW'(bus.out_valid), '0);
    chk("rst_quotient", bus.quotient, '0);
    chk("rst_remainder", bus.remainder, '0);
    chk("rst_flags", DW'({bus.div_by_zero, bus.overflow}), '0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", DW'(bus.in_ready), DW'(1));
    chk("rst_state", DW'(state_dbg), '0);

    // Directed cases
    issue('0, DW'(100), DW'(7));
    wait_drain();
    issue({{(DW-1){1'b1}}, 1'b0}, '1, '1);
    wait_drain();
    issue(rnd128(), DW'(16'h1234), '0);
    wait_drain();
    issue(DW'(5), rnd128(), DW'(5));
    wait_drain();
    issue(DW'(4), '0, DW'(5));
    wait_drain();

    // Random mix with random back-pressure
    ready_mode = 2;
    for (int i = 0; i < 30; i++) begin
      dv = rnd128();
      case ($urandom_range(0, 5))
        0: dv = '0;
        1: dv = DW'($urandom_range(1, 1000));
        default: ;
      endcase
      lo = rnd128();
      if ($urandom_range(0, 4) == 0) hi = dv + DW'($urandom_range(0, 3));
      else if (dv != 0) hi = rnd128() % dv;
      else hi = rnd128();
      if (hi < dv && dv != 0 && $urandom_range(0, 3) == 0) hi = dv - 1;
      issue(hi, lo, dv);
    end
    wait_drain();

    // Back-pressure: result held, pending request waits, accepted one cycle after handshake
    ready_mode = 0;
    hi = DW'(3); lo = rnd128(); dv = rnd128() | DW'(16);
    e = model(hi, lo, dv);
    issue(hi, lo, dv);
    n = 0;
    while (!bus.out_valid && n < 300) begin @(negedge clk); n++; end
    #2;
    chk("bp_valid_seen", DW'(bus.out_valid), DW'(1));
    hold_q = bus.quotient;
    hold_r = bus.remainder;
    chk("bp_quotient_value", hold_q, e.q);
    hs_cyc = 0;
    fork
      issue(DW'(1), DW'(77), DW'(9));
      begin
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          #2;
          chk("bp_out_valid", DW'(bus.out_valid), DW'(1));
          chk("bp_quotient", bus.quotient, hold_q);
          chk("bp_remainder", bus.remainder, hold_r);
          chk("bp_in_ready", DW'(bus.in_ready), '0);
        end
        @(negedge clk);
        hs_cyc = cyc;
        ready_mode = 1;
      end
    join
    chk("bp_next_accept", DW'(last_acc), DW'(hs_cyc + 1));
    wait_drain();

    // Reset during CALC aborts the operation
    issue(DW'(2), rnd128(), rnd128() | DW'(8));
    repeat (49) @(negedge clk);
    chk("abort_state_calc", DW'(state_dbg), DW'(1));
    rst = 1'b1;
    #1;
    exp_q.delete();
    chk("abort_out_valid", DW'(bus.out_valid), '0);
    chk("abort_quotient", bus.quotient, '0);
    chk("abort_remainder", bus.remainder, '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", DW'(bus.in_ready), DW'(1));
    chk("abort_no_result", DW'(bus.out_valid), '0);
    issue('0, DW'(9), DW'(3));
    wait_drain();

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
